reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  Debug reader for the 32x32 general-purpose register file. On request it walks
//  the register addresses through a dedicated read port, captures each value and
//  streams {addr,data} out over a valid/ready handshake toward the debug/UART path.
//  It is the read-out counterpart of the write-back port and replaces per-write
//  simulation printouts with a synthesizable, back-pressurable dump.
// PARAMETERS
//  NUM_REGS  32  registers walked per dump (addresses 0..NUM_REGS-1)
//  ADDR_W    5   register address width
//  DATA_W    32  register data width
//  BYPASS    1   1: a write to the address being read in the same cycle is forwarded
// PORTS
//  clk           in   1       system clock, all state updates on rising edge
//  rstn          in   1       synchronous reset, active-low
//  DumpReq       in   1       start a dump; sampled only in IDLE
//  DumpAbort     in   1       abandon dump in progress, return to IDLE
//  RdAddr        out  ADDR_W  address to register-file dump read port
//  RdData        in   DATA_W  combinational read data for RdAddr
//  RegWrite      in   1       write-back enable (snooped for bypass)
//  WriteRegAddr  in   ADDR_W  write-back address (snooped)
//  WriteRegData  in   DATA_W  write-back data (snooped)
//  DumpValid     out  1       DumpAddr/DumpData hold a valid beat
//  DumpReady     in   1       consumer accepts beat when DumpValid&DumpReady
//  DumpAddr      out  ADDR_W  register index of current beat
//  DumpData      out  DATA_W  register value of current beat
//  DumpLast      out  1       current beat is address NUM_REGS-1
//  Busy          out  1       high in any state except IDLE
//  DumpDone      out  1       one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset (rstn=0 at edge): state=IDLE, RdAddr=0, DumpValid=0, DumpAddr=0,
//   DumpData=0, DumpLast=0, DumpDone=0; Busy=0. Reset overrides any state, incl. mid-dump.
//  FSM states IDLE, READ, SEND, DONE:
//   IDLE: DumpReq=1 -> RdAddr<=0, go READ. Otherwise stay.
//   READ: capture DumpData<=RdData (or WriteRegData if BYPASS && RegWrite &&
//    WriteRegAddr==RdAddr && WriteRegAddr!=0); DumpAddr<=RdAddr;
//    DumpLast<=(RdAddr==NUM_REGS-1); DumpValid<=1; go SEND.
//   SEND: hold DumpValid/Addr/Data/Last stable until handshake. On DumpValid&DumpReady:
//    DumpValid<=0; if DumpLast go DONE else RdAddr<=RdAddr+1, go READ.
//   DONE: DumpDone=1 for exactly this cycle; go IDLE.
//  Throughput: 2 cycles per register with DumpReady held high; full dump of 32 regs
//   = 1 (IDLE accept) + 64 + 1 (DONE) cycles; first DumpValid 2 cycles after DumpReq.
//  Address 0 always dumps the value returned by RdData (0); bypass never applies to r0.
//  Each value is a per-register snapshot taken in its READ cycle; the dump is not
//   atomic across registers. Writes after a register's READ cycle are not reflected.
//  DumpReq while Busy: ignored (no restart, no queuing).
//  DumpAbort: highest priority after reset; from any state -> IDLE next cycle,
//   DumpValid<=0, DumpLast<=0, no DumpDone pulse. An in-flight beat is dropped even if
//   DumpReady is high that cycle. DumpAbort and DumpReq together in IDLE: stay IDLE.
//  RdAddr never exceeds NUM_REGS-1; no wrap to 0 inside a dump.
//  Busy is combinational from state (state!=IDLE); all other outputs are registered.
// TESTING
//  1 Reset: hold rstn=0 3 cycles with DumpReq=1 -> all outputs 0, Busy=0, no beat.
//  2 Preload r[i]=0x1000_0000+i, DumpReq pulse, DumpReady=1 -> 32 beats addr 0..31,
//    data 0,0x10000001..0x1000001F, DumpLast only on addr 31, DumpDone 1 cycle, 66 total.
//  3 Back-pressure: DumpReady=0 for 5 cycles at addr 7 -> DumpValid/Addr/Data stable,
//    beat accepted once when DumpReady rises; no duplicate/missing addresses.
//  4 Bypass: in READ cycle for addr 5 drive RegWrite=1, WriteRegAddr=5, 0xDEADBEEF ->
//    beat addr 5 carries 0xDEADBEEF; same for addr 0 -> beat carries 0.
//  5 Abort at addr 12 in SEND with DumpReady=1 -> DumpValid=0 next cycle, IDLE, no DumpDone;
//    new DumpReq restarts at addr 0.
//  6 DumpReq pulses mid-dump and rstn=0 at addr 20 -> ignored mid-dump; reset returns to
//    IDLE with outputs zero, next DumpReq starts cleanly at addr 0.

Source files
------------

// File: rtl/reg_dump_reader.sv
// Walks the register file through a dedicated read port and streams {addr,data} beats out, two cycles per register.
// Beats are held stable until DumpReady; DumpAbort drops any in-flight beat and returns to IDLE.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              DumpReq,
  input  logic              DumpAbort,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegAddr,
  input  logic [DATA_W-1:0] WriteRegData,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic [DATA_W-1:0] DumpData,
  output logic              DumpLast,
  output logic              Busy,
  output logic              DumpDone
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t state;
  logic   bypassHit;

  // r0 is hardwired to zero, so a write-back aimed at it must never be forwarded.
  assign bypassHit = BYPASS && RegWrite && (WriteRegAddr == RdAddr) && (WriteRegAddr != '0);
  assign Busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      RdAddr    <= '0;
      DumpValid <= 1'b0;
      DumpAddr  <= '0;
      DumpData  <= '0;
      DumpLast  <= 1'b0;
      DumpDone  <= 1'b0;
    end else if (DumpAbort) begin
      state     <= IDLE;
      DumpValid <= 1'b0;
      DumpLast  <= 1'b0;
      DumpDone  <= 1'b0;
    end else begin
      DumpDone <= 1'b0;
      case (state)
        IDLE: begin
          if (DumpReq) begin
            RdAddr <= '0;
            state  <= READ;
          end
        end
        READ: begin
          DumpData  <= bypassHit ? WriteRegData : RdData;
          DumpAddr  <= RdAddr;
          DumpLast  <= (RdAddr == LAST_ADDR);
          DumpValid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (DumpReady) begin
            DumpValid <= 1'b0;
            if (DumpLast) begin
              DumpDone <= 1'b1;
              state    <= DONE;
            end else begin
              RdAddr <= RdAddr + 1'b1;
              state  <= READ;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: register-file model, beat scoreboard, timing and control checks.
module tb_reg_dump_reader;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          DumpReq = 1'b0;
  logic          DumpAbort = 1'b0;
  logic          RegWrite = 1'b0;
  logic          DumpReady = 1'b0;
  logic [AW-1:0] WriteRegAddr = '0;
  logic [DW-1:0] WriteRegData = '0;
  logic [AW-1:0] RdAddr;
  logic [DW-1:0] RdData;
  logic          DumpValid;
  logic [AW-1:0] DumpAddr;
  logic [DW-1:0] DumpData;
  logic          DumpLast;
  logic          Busy;
  logic          DumpDone;

  int    checks = 0;
  int    errs = 0;
  beat_t sb[$];
  beat_t monE;
  logic [DW-1:0] rf [N];

  reg_dump_reader #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .BYPASS(1'b1)) dut (
    .clk(clk), .rstn(rstn), .DumpReq(DumpReq), .DumpAbort(DumpAbort),
    .RdAddr(RdAddr), .RdData(RdData), .RegWrite(RegWrite),
    .WriteRegAddr(WriteRegAddr), .WriteRegData(WriteRegData),
    .DumpValid(DumpValid), .DumpReady(DumpReady), .DumpAddr(DumpAddr),
    .DumpData(DumpData), .DumpLast(DumpLast), .Busy(Busy), .DumpDone(DumpDone)
  );

  always #5 clk = ~clk;

  assign RdData = (RdAddr == '0) ? '0 : rf[RdAddr];

  always @(posedge clk) begin
    if (RegWrite && WriteRegAddr != '0) rf[WriteRegAddr] <= WriteRegData;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A beat counts as accepted at the next rising edge unless abort or reset wins.
  always @(negedge clk) begin
    if (rstn && DumpValid && DumpReady && !DumpAbort) begin
      checks++;
      assert (sb.size() != 0) else begin
        errs++;
        $error("FAIL unexpected_beat: observed addr %0h expected no beat", DumpAddr);
      end
      if (sb.size() != 0) begin
        monE = sb.pop_front();
        chk("beat_addr", 64'(DumpAddr), 64'(monE.a));
        chk("beat_data", 64'(DumpData), 64'(monE.d));
        chk("beat_last", 64'(DumpLast), 64'(monE.l));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushDump(input bit byp);
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.a = AW'(i);
      b.d = (i == 0) ? '0 : ((byp && i == 5) ? 32'hDEADBEEF : rf[i]);
      b.l = (i == N - 1);
      sb.push_back(b);
    end
  endtask

  task automatic startDump();
    DumpReq = 1'b1;
    tick();
    DumpReq = 1'b0;
  endtask

  task automatic waitValidAddr(input logic [AW-1:0] a);
    bit found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (DumpValid && DumpAddr == a) found = 1'b1;
    end
    chk("wait_valid_addr", 64'(found), 64'd1);
  endtask

  task automatic waitRead(input logic [AW-1:0] a);
    bit found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (Busy && !DumpValid && !DumpDone && RdAddr == a) found = 1'b1;
    end
    chk("wait_read", 64'(found), 64'd1);
  endtask

  task automatic waitDone(input int start, output int n);
    bit found = 1'b0;
    n = start;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      n++;
      if (DumpDone) found = 1'b1;
    end
    chk("wait_done", 64'(found), 64'd1);
  endtask

  task automatic chkIdleZero(input string tag);
    chk({tag, "_rdaddr"}, 64'(RdAddr), 64'd0);
    chk({tag, "_valid"}, 64'(DumpValid), 64'd0);
    chk({tag, "_addr"}, 64'(DumpAddr), 64'd0);
    chk({tag, "_data"}, 64'(DumpData), 64'd0);
    chk({tag, "_last"}, 64'(DumpLast), 64'd0);
    chk({tag, "_done"}, 64'(DumpDone), 64'd0);
    chk({tag, "_busy"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    int n;
    // Reset held with a pending request.
    rstn = 1'b0;
    DumpReq = 1'b1;
    repeat (3) tick();
    chkIdleZero("reset");
    rstn = 1'b1;
    DumpReq = 1'b0;
    tick();
    chk("post_reset_busy", 64'(Busy), 64'd0);
    chk("post_reset_valid", 64'(DumpValid), 64'd0);

    for (int i = 1; i < N; i++) begin
      RegWrite = 1'b1;
      WriteRegAddr = AW'(i);
      WriteRegData = 32'h1000_0000 + 32'(i);
      tick();
    end
    RegWrite = 1'b0;

    // Full dump at full rate, with latency and cycle count.
    DumpReady = 1'b1;
    pushDump(1'b0);
    startDump();
    chk("accept_busy", 64'(Busy), 64'd1);
    chk("accept_valid", 64'(DumpValid), 64'd0);
    tick();
    chk("first_valid", 64'(DumpValid), 64'd1);
    waitDone(2, n);
    chk("cycles_to_done", 64'(n), 64'd65);
    tick();
    chk("done_one_cycle", 64'(DumpDone), 64'd0);
    chk("idle_after_done", 64'(Busy), 64'd0);
    chk("full_sb_empty", 64'(sb.size()), 64'd0);

    // Back-pressure at addr 7.
    pushDump(1'b0);
    startDump();
    waitValidAddr(5'd7);
    DumpReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 64'(DumpValid), 64'd1);
      chk("bp_addr", 64'(DumpAddr), 64'd7);
      chk("bp_data", 64'(DumpData), 64'h1000_0007);
    end
    DumpReady = 1'b1;
    waitDone(0, n);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // Same-cycle write forwarding on addr 5, never on r0.
    pushDump(1'b1);
    startDump();
    chk("byp_read0", 64'(RdAddr), 64'd0);
    RegWrite = 1'b1;
    WriteRegAddr = 5'd0;
    WriteRegData = 32'hDEADBEEF;
    tick();
    RegWrite = 1'b0;
    waitRead(5'd5);
    RegWrite = 1'b1;
    WriteRegAddr = 5'd5;
    WriteRegData = 32'hDEADBEEF;
    tick();
    RegWrite = 1'b0;
    waitDone(0, n);
    chk("byp_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // Abort at addr 12 while the consumer is ready.
    pushDump(1'b0);
    startDump();
    waitValidAddr(5'd12);
    DumpAbort = 1'b1;
    tick();
    DumpAbort = 1'b0;
    chk("abort_valid", 64'(DumpValid), 64'd0);
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_last", 64'(DumpLast), 64'd0);
    chk("abort_done", 64'(DumpDone), 64'd0);
    chk("abort_remaining", 64'(sb.size()), 64'd20);
    sb.delete();
    tick();
    chk("abort_no_done", 64'(DumpDone), 64'd0);
    DumpReq = 1'b1;
    DumpAbort = 1'b1;
    tick();
    DumpReq = 1'b0;
    DumpAbort = 1'b0;
    chk("req_abort_idle", 64'(Busy), 64'd0);
    pushDump(1'b0);
    startDump();
    waitDone(0, n);
    chk("restart_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // Ignored mid-dump request, then reset at addr 20.
    pushDump(1'b0);
    startDump();
    waitValidAddr(5'd3);
    DumpReq = 1'b1;
    tick();
    DumpReq = 1'b0;
    waitValidAddr(5'd20);
    rstn = 1'b0;
    tick();
    tick();
    chkIdleZero("midreset");
    chk("midreset_remaining", 64'(sb.size()), 64'd12);
    sb.delete();
    rstn = 1'b1;
    tick();
    chk("rearm_busy", 64'(Busy), 64'd0);
    pushDump(1'b0);
    startDump();
    waitDone(0, n);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
